// File: rtl/add_pkg.sv
// Shared constants for the adder result buffer: operand width, FIFO depth,
// stored entry width ({cout, sum}) and statistics counter width.
package add_pkg;

   localparam int W       = 64;
   localparam int DEPTH   = 4;
   localparam int ENTRY_W = W + 1;
   localparam int CNT_W   = 8;

endpackage : add_pkg

// File: rtl/add_result_buffer_sat_cnt.sv
// Saturating event counter: increments on en, holds at all-ones, never wraps.
module sat_cnt
   import add_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   output logic [CNT_W-1:0] cnt
);

   // Next value: +1 unless already at the ceiling.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      if (v == {CNT_W{1'b1}}) begin
         return v;
      end
      return v + {{(CNT_W-1){1'b0}}, 1'b1};
   endfunction

   // Counter register, cleared asynchronously by the active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= sat_inc(cnt);
      end
   end

endmodule : sat_cnt

// File: rtl/add_result_buffer.sv
// FIFO buffer sitting directly behind the 64-bit carry-select adder.
// Stores {cout, sum} entries, exposes occupancy, and keeps saturating
// statistics of carry-out results and results lost while full.
module add_result_buffer
   import add_pkg::*;
#(
   parameter int W     = add_pkg::W,
   parameter int DEPTH = add_pkg::DEPTH
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   input  logic [W-1:0]             in_sum,
   input  logic                     in_cout,
   output logic                     in_ready,
   output logic                     out_valid,
   output logic [W:0]               out_data,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   count,
   output logic [CNT_W-1:0]         carry_cnt,
   output logic [CNT_W-1:0]         drop_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [W:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          push;
   logic          pop;
   logic          drop;
   logic          carry_push;

   // Handshake flags decode from registered occupancy only; out_ready never
   // reaches in_ready, so a full buffer refuses a push even while popping.
   always_comb begin
      in_ready   = (count < CW'(DEPTH));
      out_valid  = (count != '0);
      push       = in_valid & in_ready;
      pop        = out_valid & out_ready;
      drop       = in_valid & ~in_ready;
      carry_push = push & in_cout;
      out_data   = mem[rd_ptr];
   end

   // Pointer and occupancy state; pointers wrap naturally at a power-of-two DEPTH.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Entry storage; contents need no reset because out_valid gates their use.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= {in_cout, in_sum};
      end
   end

   sat_cnt u_carry_cnt (
      .clk (clk),
      .rst (rst),
      .en  (carry_push),
      .cnt (carry_cnt)
   );

   sat_cnt u_drop_cnt (
      .clk (clk),
      .rst (rst),
      .en  (drop),
      .cnt (drop_cnt)
   );

endmodule : add_result_buffer

// File: tb/tb_add_result_buffer.sv
// Directed bench for add_result_buffer with hand-computed expected values.
module tb_add_result_buffer;
   import add_pkg::*;

   logic          clk;
   logic          rst;
   logic          in_valid;
   logic [63:0]   in_sum;
   logic          in_cout;
   logic          in_ready;
   logic          out_valid;
   logic [64:0]   out_data;
   logic          out_ready;
   logic [2:0]    count;
   logic [7:0]    carry_cnt;
   logic [7:0]    drop_cnt;

   int n_chk  = 0;
   int n_pass = 0;

   add_result_buffer #(.W(64), .DEPTH(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_sum    (in_sum),
      .in_cout   (in_cout),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .count     (count),
      .carry_cnt (carry_cnt),
      .drop_cnt  (drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
      n_chk++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; land 1 ns after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push1(input logic [63:0] s, input logic c);
      in_valid = 1'b1;
      in_sum   = s;
      in_cout  = c;
      step();
      in_valid = 1'b0;
   endtask

   logic [63:0] vals [6];
   int          k;

   initial begin
      rst       = 1'b0;
      in_valid  = 1'b0;
      in_sum    = '0;
      in_cout   = 1'b0;
      out_ready = 1'b0;
      #3;
      chk("rst_count",     65'(count),     65'd0);
      chk("rst_out_valid", 65'(out_valid), 65'd0);
      chk("rst_in_ready",  65'(in_ready),  65'd1);
      chk("rst_carry",     65'(carry_cnt), 65'd0);
      chk("rst_drop",      65'(drop_cnt),  65'd0);
      step();
      rst = 1'b1;
      step();

      // 2+5 = 7, no carry
      push1(64'd7, 1'b0);
      chk("p7_valid", 65'(out_valid), 65'd1);
      chk("p7_data",  out_data,       65'h0_0000000000000007);
      chk("p7_count", 65'(count),     65'd1);

      // all-ones + 1 = 0 with carry out
      push1(64'd0, 1'b1);
      chk("c1_count", 65'(count),     65'd2);
      chk("c1_carry", 65'(carry_cnt), 65'd1);
      chk("c1_head",  out_data,       65'h0_0000000000000007);
      out_ready = 1'b1;
      step();
      chk("c1_data",  out_data,       65'h1_0000000000000000);
      chk("c1_cnt1",  65'(count),     65'd1);
      step();
      chk("c1_empty", 65'(out_valid), 65'd0);
      // pop on empty is ignored
      step();
      chk("e_count",  65'(count),     65'd0);
      out_ready = 1'b0;

      // five pushes into a four-deep buffer
      for (int i = 0; i < 5; i++) begin
         push1(64'd10 + 64'(i), 1'b0);
         if (i == 3) begin
            chk("f_count4", 65'(count),    65'd4);
            chk("f_ready0", 65'(in_ready), 65'd0);
         end
      end
      chk("f_drop",   65'(drop_cnt), 65'd1);
      chk("f_count",  65'(count),    65'd4);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("f_data", out_data, 65'd10 + 65'(i));
         step();
      end
      chk("f_empty", 65'(out_valid), 65'd0);
      chk("f_carry", 65'(carry_cnt), 65'd1);
      out_ready = 1'b0;

      // simultaneous push and pop at count=2
      push1(64'hA1, 1'b0);
      push1(64'hB2, 1'b0);
      chk("sp_pre",   65'(count), 65'd2);
      chk("sp_old",   out_data,   65'hA1);
      out_ready = 1'b1;
      push1(64'hC3, 1'b0);
      chk("sp_count", 65'(count), 65'd2);
      chk("sp_next",  out_data,   65'hB2);
      step();
      chk("sp_last",  out_data,   65'hC3);
      step();
      chk("sp_empty", 65'(count), 65'd0);

      // streaming with out_ready=1, pointers wrap
      vals[0] = 64'd24;    vals[1] = 64'd150;   vals[2] = 64'd3072;
      vals[3] = 64'd12288; vals[4] = 64'd24000; vals[5] = 64'd2023535300;
      k = 0;
      for (int i = 0; i < 10; i++) begin
         in_valid = (i < 6);
         in_sum   = (i < 6) ? vals[i] : 64'd0;
         in_cout  = 1'b0;
         if (out_valid) begin
            if (k < 6) chk("st_data", out_data, 65'(vals[k]));
            k++;
         end
         step();
      end
      in_valid = 1'b0;
      chk("st_num", 65'(k), 65'd6);
      out_ready = 1'b0;

      // asynchronous reset mid-cycle with count=3
      push1(64'd1, 1'b1);
      push1(64'd2, 1'b0);
      push1(64'd3, 1'b0);
      chk("ar_pre",   65'(count),     65'd3);
      chk("ar_carry", 65'(carry_cnt), 65'd2);
      #2;
      rst = 1'b0;
      #1;
      chk("ar_count", 65'(count),     65'd0);
      chk("ar_valid", 65'(out_valid), 65'd0);
      chk("ar_ready", 65'(in_ready),  65'd1);
      chk("ar_carry0",65'(carry_cnt), 65'd0);
      chk("ar_drop0", 65'(drop_cnt),  65'd0);
      #1;
      rst = 1'b1;
      push1(64'd99, 1'b0);
      chk("ar_head",  out_data,   65'd99);
      chk("ar_cnt1",  65'(count), 65'd1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule : tb_add_result_buffer

// File: doc/add_result_buffer.md
ADD_RESULT_BUFFER -- requirements
Module: add_result_buffer

Interface
REQ-001 SHALL have parameter W, default 64, adder operand/sum width.
REQ-002 SHALL have parameter DEPTH, default 4, FIFO entries, power of two, at least 2.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  adder result present this cycle.
REQ-006 SHALL have port in_sum  input  W  sum from the 64-bit carry-select adder.
REQ-007 SHALL have port in_cout  input  1  carry-out from the adder.
REQ-008 SHALL have port in_ready  output  1  buffer can accept an entry this cycle.
REQ-009 SHALL have port out_valid  output  1  head entry available.
REQ-010 SHALL have port out_data  output  W+1  head entry {cout, sum}.
REQ-011 SHALL have port out_ready  input  1  consumer accepts head entry.
REQ-012 SHALL have port count  output  log2(DEPTH)+1  current occupancy.
REQ-013 SHALL have port carry_cnt  output  8  saturating count of accepted entries with cout=1.
REQ-014 SHALL have port drop_cnt  output  8  saturating count of results lost while full.

Function
REQ-015 Push SHALL occur when in_valid=1 and in_ready=1; the entry written is {in_cout, in_sum}.
REQ-016 Pop SHALL occur when out_valid=1 and out_ready=1.
REQ-017 in_ready SHALL equal (count < DEPTH), decoded from registered count only, with no dependence on out_ready.
REQ-018 out_valid SHALL equal (count != 0); out_data SHALL show the head entry, registered storage, with no input bypass.
REQ-019 Latency: an entry pushed at edge N SHALL appear on out_data with out_valid=1 after edge N.
REQ-020 Order SHALL be strict FIFO; read and write pointers SHALL wrap modulo DEPTH.
REQ-021 Simultaneous push and pop with 0<count<DEPTH SHALL leave count unchanged and advance both pointers.
REQ-022 When full, in_ready=0, so no push occurs even if a pop happens the same cycle.
REQ-023 When empty, a pop request SHALL be ignored, and pointers and count SHALL stay unchanged.
REQ-024 in_valid=1 with in_ready=0 SHALL increment drop_cnt, and the entry SHALL be discarded.
REQ-025 A push with in_cout=1 SHALL increment carry_cnt.
REQ-026 Both counters SHALL saturate at 255 and never wrap.
REQ-027 out_data for empty slots SHALL be don't-care; out_valid gates use.

Reset
REQ-028 On rst=0, asynchronously: pointers=0, count=0, carry_cnt=0, drop_cnt=0, out_valid=0, in_ready=1.
REQ-029 Reset mid-operation SHALL discard all stored entries; the first push after release SHALL be the head.
REQ-030 Storage array contents SHALL need no reset.

Structure
REQ-031 Shared package add_pkg SHALL hold W, DEPTH, the entry width constant (W+1) and the counter width 8.
REQ-032 One sub-module, sat_cnt (8-bit saturating incrementer with enable), SHALL be instantiated twice, for carry_cnt and drop_cnt.
REQ-033 The block SHALL sit directly downstream of the 64-bit carry-select adder and consume its sum and cout unchanged.

Verification
REQ-034 Push sum=7, cout=0 (2+5); out_ready=0 -> next cycle out_valid=1, out_data=0x0_0000000000000007, count=1.
REQ-035 Push sum=0, cout=1 (0xFFFFFFFFFFFFFFFF+1) -> out_data MSB=1, carry_cnt=1.
REQ-036 Five consecutive pushes with out_ready=0 -> count=4, in_ready=0 after the fourth push, drop_cnt=1, and the fifth value is never seen.
REQ-037 At count=2, push and pop in the same cycle -> count stays 2, popped value is the oldest entry.
REQ-038 Push 24, 150, 3072, 12288, 24000, 2023535300 with out_ready=1 -> all six values come out in order, exercising pointer wrap.
REQ-039 Pulse rst=0 mid-cycle with count=3 -> count=0, out_valid=0, and counters clear immediately without waiting for a clock edge.
